// File: rtl/fir_pkg.sv
// Shared defaults and types for the FIR coefficient path: tap count, widths,
// loader state encoding and signed coefficient / LUT entry types.
package fir_pkg;

    localparam int TAPS   = 4;
    localparam int COEF_W = 16;
    localparam int SUM_W  = COEF_W + $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUILD
    } loader_state_t;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [SUM_W-1:0]  lut_entry_t;

endpackage

// File: rtl/da_lut_ram.sv
// Distributed-arithmetic partial-sum LUT: one synchronous write port, one
// synchronous fetch port for the build, one registered external read port.
module da_lut_ram
    import fir_pkg::*;
#(
    parameter int ADDR_W = TAPS,
    parameter int DATA_W = SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_fetch_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // NOTE: the array carries no reset so it can map onto RAM; its contents are only meaningful after a complete build.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        o_fetch_data <= r_mem[i_fetch_addr];
    end

    // Reads and writes to the same address in one cycle return the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/da_coef_loader.sv
// Coefficient loader: accepts TAPS coefficients, builds the 2^TAPS DA partial-sum
// LUT one entry per cycle, then raises cload. Optional coef_chk output under DA_COEF_LOADER_CHECKSUM_EN.
module da_coef_loader #(
    parameter int TAPS   = fir_pkg::TAPS,
    parameter int COEF_W = fir_pkg::COEF_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load_start,
    input  logic                                  coef_valid,
    input  logic [COEF_W-1:0]                     coef_data,
    output logic                                  coef_ready,
    output logic                                  busy,
    output logic                                  cload,
    input  logic [TAPS-1:0]                       lut_rd_addr,
    output logic [COEF_W+$clog2(TAPS)-1:0]        lut_rd_data
`ifdef DA_COEF_LOADER_CHECKSUM_EN
    ,
    output logic [COEF_W-1:0]                     coef_chk
`endif
);

    import fir_pkg::*;

    localparam int SUM_W = COEF_W + $clog2(TAPS);
    localparam int IDX_W = $clog2(TAPS);

    loader_state_t     r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [TAPS-1:0]   r_k;
    logic              r_coef_ready;
    logic              r_busy;
    logic              r_cload;
    logic [COEF_W-1:0] r_coef [TAPS];

    logic              w_accept;
    logic              w_we;
    logic [TAPS-1:0]   w_k_next;
    logic [TAPS-1:0]   w_fetch_addr;
    logic [IDX_W-1:0]  w_tap;
    logic [SUM_W-1:0]  w_fetch_data;
    logic [SUM_W-1:0]  w_base;
    logic [SUM_W-1:0]  w_addend;
    logic [SUM_W-1:0]  w_wdata;

    function automatic logic [IDX_W-1:0] msb_of(input logic [TAPS-1:0] v);
        msb_of = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (v[i]) msb_of = IDX_W'(i);
        end
    endfunction

    assign w_accept = (r_state == LOAD) && coef_valid && r_coef_ready;
    assign w_we     = (r_state == BUILD);

    // Fetch lut[k+1 - 2^m] one cycle ahead; clearing the MSB of k+1 gives that address.
    assign w_k_next     = r_k + 1'b1;
    assign w_fetch_addr = w_k_next & ~(TAPS'(1) << msb_of(w_k_next));

    // Powers of two build on lut[0], which may still be in flight, so use zero directly.
    assign w_tap    = msb_of(r_k);
    assign w_base   = ((r_k & (r_k - 1'b1)) == '0) ? '0 : w_fetch_data;
    assign w_addend = {{(SUM_W-COEF_W){r_coef[w_tap][COEF_W-1]}}, r_coef[w_tap]};
    assign w_wdata  = (r_k == '0) ? '0 : w_base + w_addend;

    // NOTE: all state here updates with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_coef_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_cload      <= 1'b0;
            r_idx        <= '0;
            r_k          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_state      <= LOAD;
                        r_cload      <= 1'b0;
                        r_idx        <= '0;
                        r_coef_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IDX_W'(TAPS-1)) begin
                            r_state      <= BUILD;
                            r_coef_ready <= 1'b0;
                            r_k          <= '0;
                        end
                    end
                end
                BUILD: begin
                    r_k <= w_k_next;
                    if (r_k == '1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cload <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_coef[r_idx] <= coef_data;
        end
    end

`ifdef DA_COEF_LOADER_CHECKSUM_EN
    logic [COEF_W-1:0] r_chk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chk <= '0;
        end else if (r_state == IDLE && load_start) begin
            r_chk <= '0;
        end else if (w_accept) begin
            r_chk <= r_chk ^ coef_data;
        end
    end

    assign coef_chk = r_chk;
`endif

    da_lut_ram #(
        .ADDR_W (TAPS),
        .DATA_W (SUM_W)
    ) u_lut (
        .clk          (clk),
        .reset        (reset),
        .i_we         (w_we),
        .i_waddr      (r_k),
        .i_wdata      (w_wdata),
        .i_fetch_addr (w_fetch_addr),
        .o_fetch_data (w_fetch_data),
        .i_rd_addr    (lut_rd_addr),
        .o_rd_data    (lut_rd_data)
    );

    assign coef_ready = r_coef_ready;
    assign busy       = r_busy;
    assign cload      = r_cload;

endmodule

// File: tb/tb_da_coef_loader.sv
// Randomized self-checking bench for da_coef_loader; LUT entries are predicted
// as plain sums of the selected coefficients.
module tb_da_coef_loader;

    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              coef_valid;
    logic [COEF_W-1:0] coef_data;
    logic              coef_ready;
    logic              busy;
    logic              cload;
    logic [TAPS-1:0]   lut_rd_addr;
    logic [SUM_W-1:0]  lut_rd_data;
`ifdef DA_COEF_LOADER_CHECKSUM_EN
    logic [COEF_W-1:0] coef_chk;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int ready_cyc;
    int busy_cyc;
    int lat;
    logic signed [COEF_W-1:0] mdl_coef [TAPS];

    always #5 clk = ~clk;

    da_coef_loader dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .coef_valid  (coef_valid),
        .coef_data   (coef_data),
        .coef_ready  (coef_ready),
        .busy        (busy),
        .cload       (cload),
        .lut_rd_addr (lut_rd_addr),
        .lut_rd_data (lut_rd_data)
`ifdef DA_COEF_LOADER_CHECKSUM_EN
        ,
        .coef_chk    (coef_chk)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entry k is the sum of the coefficients whose tap bit is set in k.
    function automatic logic [SUM_W-1:0] exp_lut(input int k);
        int s = 0;
        for (int i = 0; i < TAPS; i++) begin
            if (k[i]) s += int'(mdl_coef[i]);
        end
        return SUM_W'(s);
    endfunction

    // mode 0: back-to-back beats, 1: valid every other cycle, 2: random gaps.
    // poke: extra load_start pulses in LOAD and mid-BUILD that must be ignored.
    task automatic run_load(input logic [COEF_W-1:0] c [TAPS], input int mode, input bit poke);
        int acc = 0;
        int cyc = 0;
        int last_acc = -1;
        bit fire;
        ready_cyc = 0;
        busy_cyc  = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("cload_drop", cload, 0);
        check("busy_rise", busy, 1);
`ifdef DA_COEF_LOADER_CHECKSUM_EN
        check("chk_clear", coef_chk, 0);
`endif
        while (!cload && cyc < 300) begin
            busy_cyc  += int'(busy);
            ready_cyc += int'(coef_ready);
            coef_valid = (acc < TAPS) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                                          (mode == 2 && $urandom_range(0, 1) == 1));
            coef_data  = (acc < TAPS) ? c[acc] : COEF_W'($urandom);
            load_start = poke && (cyc == 1 || (last_acc >= 0 && cyc == last_acc + 5));
            fire = coef_valid && coef_ready;
            tick();
            cyc++;
            if (fire) begin
                acc++;
                if (acc == TAPS) last_acc = cyc;
            end
        end
        coef_valid = 1'b0;
        load_start = 1'b0;
        for (int i = 0; i < TAPS; i++) mdl_coef[i] = c[i];
        check("load_done", cload, 1);
        lat = cyc - last_acc;
        check("build_latency", lat, 2**TAPS);
        check("busy_span", busy_cyc, ready_cyc + 2**TAPS);
        check("busy_fall", busy, 0);
`ifdef DA_COEF_LOADER_CHECKSUM_EN
        begin
            logic [COEF_W-1:0] x = '0;
            for (int i = 0; i < TAPS; i++) x ^= c[i];
            check("chk_value", coef_chk, x);
        end
`endif
    endtask

    task automatic verify_lut(input string tag);
        for (int k = 0; k < 2**TAPS; k++) begin
            lut_rd_addr = TAPS'(k);
            tick();
            check($sformatf("%s[%0d]", tag, k), lut_rd_data, exp_lut(k));
        end
    endtask

    task automatic read_one(input int k, output logic [SUM_W-1:0] d);
        lut_rd_addr = TAPS'(k);
        tick();
        d = lut_rd_data;
    endtask

    initial begin
        logic [COEF_W-1:0] c [TAPS];
        logic [SUM_W-1:0]  d;

        reset       = 1'b1;
        load_start  = 1'b0;
        coef_valid  = 1'b0;
        coef_data   = '0;
        lut_rd_addr = '0;
        repeat (2) tick();
        check("rst_coef_ready", coef_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cload", cload, 0);
        check("rst_rd_data", lut_rd_data, 0);
        reset = 1'b0;
        tick();
        check("idle_cload", cload, 0);

        // Powers of two: every entry equals its own address.
        c = '{16'd1, 16'd2, 16'd4, 16'd8};
        run_load(c, 0, 1'b0);
        check("ready_cycles", ready_cyc, 4);
        check("busy_cycles", busy_cyc, 20);
        verify_lut("lut_pow2");
        read_one(9, d);
        check("lut9_const", d, 9);

        // Negative coefficients exercise sign extension into SUM_W.
        c = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8};
        run_load(c, 0, 1'b0);
        verify_lut("lut_neg");
        read_one(15, d);
        check("lut15_neg", d, 18'h3FFF1);
        read_one(5, d);
        check("lut5_neg", d, 18'h3FFFB);

        // Full-scale positive coefficients with a stalling producer.
        c = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_load(c, 1, 1'b0);
        check("ready_cycles_gap", ready_cyc, 7);
        verify_lut("lut_max");
        read_one(15, d);
        check("lut15_max", d, 18'h1FFFC);

        // Reload with stray load_start pulses that must not restart anything.
        for (int i = 0; i < TAPS; i++) c[i] = COEF_W'($urandom);
        run_load(c, 0, 1'b1);
        tick();
        check("no_restart_cload", cload, 1);
        check("no_restart_ready", coef_ready, 0);
        verify_lut("lut_poke");

        // Reset during the second LOAD beat.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        coef_valid = 1'b1;
        coef_data  = COEF_W'($urandom);
        tick();
        reset      = 1'b1;
        coef_data  = COEF_W'($urandom);
        tick();
        reset      = 1'b0;
        coef_valid = 1'b0;
        check("midrst_ready", coef_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cload", cload, 0);
        tick();
        check("midrst_idle", busy, 0);

        // Reset wins over a simultaneous load_start.
        reset      = 1'b1;
        load_start = 1'b1;
        tick();
        reset      = 1'b0;
        load_start = 1'b0;
        check("rst_vs_start_busy", busy, 0);
        check("rst_vs_start_ready", coef_ready, 0);

        for (int i = 0; i < TAPS; i++) c[i] = COEF_W'($urandom);
        run_load(c, 2, 1'b0);
        verify_lut("lut_after_rst");

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < TAPS; i++) c[i] = COEF_W'($urandom);
            run_load(c, 2, n[0]);
            verify_lut($sformatf("lut_rand%0d", n));
        end

`ifdef DA_COEF_LOADER_CHECKSUM_EN
        c = '{16'h0001, 16'h00F0, 16'h0F00, 16'hF000};
        run_load(c, 0, 1'b0);
        check("chk_fff1", coef_chk, 16'hFFF1);
        tick();
        check("chk_stable", coef_chk, 16'hFFF1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
